// File: rtl/timer_prescaler.sv
// timer_prescaler: count-enable generator for the main timer counter (power-of-two / linear divide, shadow limit, debug halt).
// Latency: count_en is combinational off the registered counter/limit; halt_ack follows halt_req by one cycle.
// Backpressure: none; halt_req freezes the prescale counter and masks count_en in the same cycle.
module timer_prescaler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_timer_en,
  input  logic             i_div_en,
  input  logic             i_div_mode,
  input  logic [CNT_W-1:0] i_div_val,
  input  logic             i_halt_req,
  output logic             o_count_en,
  output logic             o_halt_ack,
  output logic [CNT_W-1:0] o_div_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_lim_q;
  logic [CNT_W-1:0] w_lim_next;
  logic [CNT_W-1:0] w_pow2_lim;
  logic [32:0]      w_val_ext;
  logic             w_idle_load;
  logic             w_at_lim;
  logic             w_wrap;

  // Widened so the shift amount can be compared against CNT_W even when CNT_W=32.
  assign w_val_ext   = 33'(i_div_val);
  assign w_idle_load = !i_timer_en || !i_div_en;
  assign w_at_lim    = (r_div_cnt == r_lim_q);
  // A wrap is the cycle the counter actually returns to 0 from the limit; a halted
  // cycle sitting on the limit is not a wrap, so the new limit lands with the new period.
  assign w_wrap      = i_timer_en && i_div_en && !i_halt_req && w_at_lim;

  // Power-of-two limit: bit k set when k < div_val, which is (1<<div_val)-1 and saturates to all-ones.
  always_comb begin
    w_pow2_lim = '0;
    for (int k = 0; k < CNT_W; k++) begin
      w_pow2_lim[k] = (33'(k) < w_val_ext);
    end
  end

  // Limit decode selected by divide mode.
  always_comb begin
    w_lim_next = i_div_mode ? i_div_val : w_pow2_lim;
  end

  // Shadow limit: reload only while idle or on a wrap so a period is never cut short or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lim_q <= '0;
    end else if (w_idle_load || w_wrap) begin
      r_lim_q <= w_lim_next;
    end
  end

  // Prescale counter: clear when disabled, freeze on halt, wrap at the shadow limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_idle_load) begin
      r_div_cnt <= '0;
    end else if (i_halt_req) begin
      r_div_cnt <= r_div_cnt;
    end else if (w_at_lim) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // State register for the debug-halt handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping timer_en returns to IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_timer_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = i_halt_req ? ST_HALT : ST_RUN;
        ST_RUN:  if (i_halt_req) w_state_nxt = ST_HALT;
        ST_HALT: if (!i_halt_req) w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs; count_en is gated by rst_n because the reset limit of 0 would otherwise strobe during reset.
  always_comb begin
    o_halt_ack = (r_state == ST_HALT);
    o_count_en = rst_n && i_timer_en && !i_halt_req &&
                 (!i_div_en || (r_lim_q == '0) || w_at_lim);
  end

  assign o_div_cnt = r_div_cnt;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler (CNT_W=8): hand-computed strobe positions,
// counter values and halt handshake timing for each scenario.
module tb_timer_prescaler;

  logic       clk;
  logic       rst_n;
  logic       timer_en;
  logic       div_en;
  logic       div_mode;
  logic [7:0] div_val;
  logic       halt_req;
  logic       count_en;
  logic       halt_ack;
  logic [7:0] div_cnt;

  int n_cmp = 0;
  int n_err = 0;

  timer_prescaler #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_timer_en (timer_en),
    .i_div_en   (div_en),
    .i_div_mode (div_mode),
    .i_div_val  (div_val),
    .i_halt_req (halt_req),
    .o_count_en (count_en),
    .o_halt_ack (halt_ack),
    .o_div_cnt  (div_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    timer_en = 1'b0;
    div_en   = 1'b0;
    div_mode = 1'b0;
    div_val  = 8'd0;
    halt_req = 1'b0;

    // Reset state
    #3;
    chk("rst count_en", 32'(count_en), 32'd0);
    chk("rst halt_ack", 32'(halt_ack), 32'd0);
    chk("rst div_cnt",  32'(div_cnt),  32'd0);
    #9 rst_n = 1'b1;
    cyc();

    // Power-of-two, div_val=3 -> period 8, pulses on enabled cycles 7, 15, 23
    div_en = 1'b1; div_mode = 1'b0; div_val = 8'd3;
    cyc();
    timer_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      chk($sformatf("p2_3 count_en i=%0d", i), 32'(count_en), 32'(i % 8 == 7));
      chk($sformatf("p2_3 div_cnt i=%0d", i),  32'(div_cnt),  32'(i % 8));
      cyc();
    end

    // Power-of-two, div_val=12 saturates -> period 256
    timer_en = 1'b0; div_val = 8'd12;
    cyc();
    timer_en = 1'b1;
    for (int i = 0; i < 520; i++) begin
      #1;
      chk($sformatf("p2_sat count_en i=%0d", i), 32'(count_en), 32'(i % 256 == 255));
      cyc();
    end

    // Linear, div_val=4; change to 9 at div_cnt=2 -> pulses at 4, 14, 24
    timer_en = 1'b0; div_mode = 1'b1; div_val = 8'd4;
    cyc();
    timer_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) div_val = 8'd9;
      #1;
      chk($sformatf("lin count_en i=%0d", i), 32'(count_en), 32'(i == 4 || i == 14 || i == 24));
      chk($sformatf("lin div_cnt i=%0d", i),  32'(div_cnt),  (i <= 4) ? i : (i - 5) % 10);
      cyc();
    end

    // Halt for 3 cycles at div_cnt=5 with limit 7 -> pulse moves from 7 to 10
    timer_en = 1'b0; div_mode = 1'b1; div_val = 8'd7;
    cyc();
    timer_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      halt_req = (i >= 5 && i <= 7);
      #1;
      chk($sformatf("halt count_en i=%0d", i), 32'(count_en), 32'(i == 10 || i == 18));
      chk($sformatf("halt div_cnt i=%0d", i),  32'(div_cnt),  (i < 5) ? i : (i <= 8) ? 5 : (i - 3) % 8);
      chk($sformatf("halt ack i=%0d", i),      32'(halt_ack), 32'(i >= 6 && i <= 8));
      cyc();
    end
    halt_req = 1'b0;

    // Halt coinciding with the wrap: counter holds at limit, strobe on first non-halted cycle
    timer_en = 1'b0; div_val = 8'd3;
    cyc();
    timer_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      halt_req = (i == 3 || i == 4);
      #1;
      chk($sformatf("hwrap count_en i=%0d", i), 32'(count_en), 32'(i == 5 || i == 9));
      chk($sformatf("hwrap div_cnt i=%0d", i),  32'(div_cnt),  (i <= 5) ? ((i < 3) ? i : 3) : (i - 6) % 4);
      chk($sformatf("hwrap ack i=%0d", i),      32'(halt_ack), 32'(i == 4 || i == 5));
      cyc();
    end
    halt_req = 1'b0;

    // Degenerate: div_en=0 (also idle-loads linear limit 0)
    div_en = 1'b0; div_mode = 1'b1; div_val = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("nodiv count_en i=%0d", i), 32'(count_en), 32'd1);
      cyc();
    end
    halt_req = 1'b1; #1;
    chk("nodiv halt mask", 32'(count_en), 32'd0);
    cyc(); halt_req = 1'b0;

    // Degenerate: linear div_val=0
    div_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lin0 count_en i=%0d", i), 32'(count_en), 32'd1);
      chk($sformatf("lin0 div_cnt i=%0d", i),  32'(div_cnt),  32'd0);
      cyc();
    end
    halt_req = 1'b1; #1;
    chk("lin0 halt mask", 32'(count_en), 32'd0);
    cyc(); halt_req = 1'b0;

    // Degenerate: power-of-two div_val=0
    div_en = 1'b0; div_mode = 1'b0; div_val = 8'd0;
    cyc();
    div_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("p2_0 count_en i=%0d", i), 32'(count_en), 32'd1);
      cyc();
    end
    halt_req = 1'b1; #1;
    chk("p2_0 halt mask", 32'(count_en), 32'd0);
    cyc(); halt_req = 1'b0;

    // Enable drop during HALT, then re-enable with halt still requested
    timer_en = 1'b0; div_mode = 1'b1; div_val = 8'd7;
    cyc();
    timer_en = 1'b1;
    cyc(); cyc(); cyc();
    halt_req = 1'b1;
    cyc();
    #1;
    chk("drop ack in halt",  32'(halt_ack), 32'd1);
    chk("drop cnt in halt",  32'(div_cnt),  32'd3);
    timer_en = 1'b0; #1;
    chk("drop count_en",     32'(count_en), 32'd0);
    cyc();
    chk("drop ack after",    32'(halt_ack), 32'd0);
    chk("drop cnt after",    32'(div_cnt),  32'd0);
    timer_en = 1'b1; #1;
    chk("reen ack idle",     32'(halt_ack), 32'd0);
    cyc();
    chk("reen ack halt",     32'(halt_ack), 32'd1);
    chk("reen cnt",          32'(div_cnt),  32'd0);
    chk("reen count_en",     32'(count_en), 32'd0);
    halt_req = 1'b0;
    cyc();

    // Asynchronous reset mid-run at div_cnt=37
    timer_en = 1'b0; div_mode = 1'b1; div_val = 8'd100;
    cyc();
    timer_en = 1'b1;
    repeat (37) cyc();
    #1;
    chk("pre-rst div_cnt", 32'(div_cnt), 32'd37);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count_en", 32'(count_en), 32'd0);
    chk("async rst halt_ack", 32'(halt_ack), 32'd0);
    chk("async rst div_cnt",  32'(div_cnt),  32'd0);
    timer_en = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post-rst halt_ack", 32'(halt_ack), 32'd0);
    chk("post-rst div_cnt",  32'(div_cnt),  32'd0);
    timer_en = 1'b1; halt_req = 1'b1; #1;
    chk("post-rst idle ack", 32'(halt_ack), 32'd0);
    cyc();
    chk("post-rst halt ack", 32'(halt_ack), 32'd1);
    halt_req = 1'b0; timer_en = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_prescaler.md
# timer_prescaler

Parametrised count-enable generator for the timer IP. It sits between the timer control registers and the main timer counter, and produces the `count_en` strobe that advances the main counter. It supports a power-of-two or a linear divide ratio, CNT_W-bit prescale range, and glitch-free divisor updates through a shadow limit register. Debug halt is a registered handshake driven by a small IDLE/RUN/HALT state machine.

## Interface
- `CNT_W`, default 8: prescale counter width; legal range 2..32. Maximum divide ratio is 2^CNT_W.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `timer_en`  input  1  timer enable; 0 forces IDLE and clears the prescale counter.
- `div_en`  input  1  divide enable; 0 means count on every enabled cycle.
- `div_mode`  input  1  divide mode: 0 = power-of-two, 1 = linear.
- `div_val`  input  CNT_W  divide setting, interpreted per `div_mode`.
- `halt_req`  input  1  debug halt request, level-sensitive.
- `count_en`  output  1  single-cycle strobe that advances the main timer counter.
- `halt_ack`  output  1  high while the state machine is in HALT.
- `div_cnt`  output  CNT_W  current prescale counter value, for debug/readback.

## Operation
- **Limit decode (combinational), `lim_next`:**
  - `div_mode=0`: `(1<<div_val)-1` when `div_val<CNT_W`; otherwise all-ones, i.e. saturates at 2^CNT_W-1.
  - `div_mode=1`: `div_val` used directly.
- **Shadow limit `lim_q`:** CNT_W bits, reset 0. It loads `lim_next` in two cases:
  - on every cycle where `!timer_en | !div_en` (idle load);
  - on a wrap cycle, i.e. RUN with `div_en=1` and `div_cnt==lim_q`.
  - At all other times `lim_q` holds, so `div_val` changes mid-period never truncate or stretch the current period.
- **Prescale counter `div_cnt`:** reset 0. Priority, highest first:
  1. `!timer_en | !div_en` → 0.
  2. `halt_req` → hold.
  3. `div_cnt==lim_q` → 0.
  4. Otherwise `div_cnt+1`.
  - Wrap is CNT_W-bit; `div_cnt` never exceeds `lim_q`.
- **State machine**, 2-bit state, reset IDLE:
  - IDLE → RUN when `timer_en & !halt_req`.
  - IDLE → HALT when `timer_en & halt_req`.
  - RUN → HALT when `halt_req`.
  - HALT → RUN when `!halt_req`.
  - Any state → IDLE when `!timer_en`; this has highest priority.
- **`halt_ack`** = (state==HALT), registered.
- **`count_en`** = `timer_en & !halt_req & (!div_en | lim_q==0 | div_cnt==lim_q)`.
  - The halt mask is combinational, so the strobe is suppressed in the same cycle that `halt_req` rises.
- **Resulting divide ratio** is `lim_q+1` enabled, non-halted cycles per `count_en` pulse.
  - Power-of-two: 2^div_val.
  - Linear: div_val+1.

## Timing
- **Reset values:** `count_en=0`, `halt_ack=0`, `div_cnt=0`, `lim_q=0`, state IDLE.
- **First enabled cycle:** `div_cnt=0`. `lim_q` holds the `div_val`/`div_mode` sampled on the last idle cycle. A `div_val` change in the same cycle that `timer_en`/`div_en` rises takes effect at the first wrap.
- **First `count_en` pulse:** occurs on enabled cycle index `lim_q`, counting from 0.
- **Divisor change:** a change applied at any `div_cnt` value takes effect for the period that begins immediately after the next wrap.
- **`halt_ack` latency:**
  - Rises 1 cycle after `halt_req` rises, provided `timer_en=1`.
  - Falls 1 cycle after `halt_req` falls.
  - `div_cnt` is frozen in every cycle where `halt_req=1`, including the cycle before `halt_ack` rises.
- **`timer_en` falls during HALT or RUN:**
  - `div_cnt` is 0 from the next edge.
  - `halt_ack` is 0 from the next edge.
  - `count_en` is 0 combinationally.
- **`div_en` falls mid-period:** `div_cnt` clears at the next edge. `count_en` becomes `timer_en & !halt_req` in the same cycle.
- **`halt_req` and wrap in the same cycle:** halt wins. `div_cnt` holds at `lim_q`, no strobe is issued, and the strobe fires on the first non-halted cycle.

## Test plan
1. **Reset:** assert `rst_n=0` mid-run with `div_cnt=37` → `count_en`, `halt_ack` and `div_cnt` are all 0 asynchronously; after release the state is IDLE.
2. **Power-of-two divide:** `CNT_W=8`, `div_mode=0`, `div_val=3`, `div_en=1`, then `timer_en` 0→1 → `count_en` pulses on enabled cycles 7, 15, 23 (period 8). With `div_val=12` → saturation, period 256.
3. **Linear divide with mid-period change:** `div_mode=1`, `div_val=4` → period 5. Write `div_val=9` at `div_cnt=2` → the pulse still occurs at `div_cnt=4`; the next pulses are 10 cycles apart.
4. **Halt handshake:** hold `halt_req=1` for 3 cycles starting at `div_cnt=5` with `lim_q=7` → `div_cnt` holds at 5 and `count_en` stays 0. `halt_ack` is high for 3 cycles, delayed by one cycle. The pulse is delayed by exactly 3 cycles.
5. **Degenerate ratios:**
   - `div_en=0` → `count_en` high every cycle.
   - `div_en=1` with linear `div_val=0` → `count_en` high every cycle.
   - `div_en=1` with power-of-two `div_val=0` → `count_en` high every cycle.
   - `halt_req=1` masks `count_en` in the same cycle in all three cases.
6. **Enable drop during halt:** in HALT, drop `timer_en` → next cycle IDLE, `halt_ack=0`, `div_cnt=0`. Re-enable with `halt_req=1` still high → IDLE→HALT, `halt_ack=1` after 1 cycle.
